// File: rtl/add_share_sched.sv
// add_share_sched: round-robin scheduler that time-multiplexes one registered
// 2-input adder across NREQ requesters. Each request returns (a+b)+(c+d),
// computed in three adder passes (AB, CD, SUM). The result is then held in a
// valid/ready response slot (DONE).
// Optional build macro: ADD_SHARE_SCHED_STATS_EN adds the ops_done and
// stall_cycles saturating counter outputs.
module add_share_sched #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   input  logic [NREQ*W-1:0]   req_c,
   input  logic [NREQ*W-1:0]   req_d,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [W+1:0]        rsp_data,
   output logic [IDW-1:0]      rsp_id,
   output logic                busy
`ifdef ADD_SHARE_SCHED_STATS_EN
   ,
   output logic [15:0]         ops_done,
   output logic [15:0]         stall_cycles
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AB   = 3'd1,
      ST_CD   = 3'd2,
      ST_SUM  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t          state_reg;
   state_t          state_next;

   logic [IDW-1:0]  ptr_reg;
   logic [IDW-1:0]  id_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    c_reg;
   logic [W-1:0]    d_reg;
   logic [W:0]      s_ab_reg;
   logic [W+1:0]    sreg;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            take;
   logic [IDW:0]    cand;
   logic [IDW-1:0]  cand_id;

   logic [W:0]      add_x;
   logic [W:0]      add_y;
   logic [W+1:0]    add_sum;

   // Unpacked per-requester operand views, so the grant index can select them.
   logic [W-1:0]    a_arr [NREQ];
   logic [W-1:0]    b_arr [NREQ];
   logic [W-1:0]    c_arr [NREQ];
   logic [W-1:0]    d_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*W +: W];
         assign b_arr[gi] = req_b[gi*W +: W];
         assign c_arr[gi] = req_c[gi*W +: W];
         assign d_arr[gi] = req_d[gi*W +: W];
      end
   endgenerate

   // Rotating-priority search starting just after the last granted requester.
   // The grant is only offered in IDLE and is forced off while rst is high.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      take     = 1'b0;
      cand     = '0;
      cand_id  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         cand_id = cand[IDW-1:0];
         if (!take && req_valid[cand_id]) begin
            take            = 1'b1;
            grant[cand_id]  = 1'b1;
            grant_id        = cand_id;
         end
      end
      if (state_reg != ST_IDLE || rst) begin
         grant = '0;
         take  = 1'b0;
      end
   end

   assign req_ready = grant;

   // Operand select for the single shared adder, steered by the FSM pass.
   always_comb begin
      add_x = '0;
      add_y = '0;
      case (state_reg)
         ST_AB: begin
            add_x = {1'b0, a_reg};
            add_y = {1'b0, b_reg};
         end
         ST_CD: begin
            add_x = {1'b0, c_reg};
            add_y = {1'b0, d_reg};
         end
         ST_SUM: begin
            add_x = s_ab_reg;
            add_y = sreg[W:0];
         end
         default: begin
            add_x = '0;
            add_y = '0;
         end
      endcase
   end

   assign add_sum = {1'b0, add_x} + {1'b0, add_y};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state: three adder passes, then hold until the response is taken.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (take) state_next = ST_AB;
         ST_AB:   state_next = ST_CD;
         ST_CD:   state_next = ST_SUM;
         ST_SUM:  state_next = ST_DONE;
         ST_DONE: if (rsp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Request capture, round-robin pointer and the adder's pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg  <= IDW'(NREQ-1);
         id_reg   <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         c_reg    <= '0;
         d_reg    <= '0;
         s_ab_reg <= '0;
         sreg     <= '0;
      end else begin
         if (take) begin
            a_reg   <= a_arr[grant_id];
            b_reg   <= b_arr[grant_id];
            c_reg   <= c_arr[grant_id];
            d_reg   <= d_arr[grant_id];
            id_reg  <= grant_id;
            ptr_reg <= grant_id;
         end
         case (state_reg)
            ST_AB: begin
               sreg <= add_sum;
            end
            ST_CD: begin
               s_ab_reg <= sreg[W:0];
               sreg     <= add_sum;
            end
            ST_SUM: begin
               sreg <= add_sum;
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_valid = (state_reg == ST_DONE);
   assign rsp_data  = sreg;
   assign rsp_id    = id_reg;
   assign busy      = (state_reg != ST_IDLE);

`ifdef ADD_SHARE_SCHED_STATS_EN
   // Saturating counters for completed responses and backpressured cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_done     <= '0;
         stall_cycles <= '0;
      end else begin
         if (rsp_valid && rsp_ready && ops_done != 16'hFFFF) begin
            ops_done <= ops_done + 16'd1;
         end
         if (rsp_valid && !rsp_ready && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// Directed testbench for add_share_sched (default build, NREQ=4, W=8).
module tb_add_share_sched;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;
   logic [NREQ*W-1:0]   req_c;
   logic [NREQ*W-1:0]   req_d;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [W+1:0]        rsp_data;
   logic [IDW-1:0]      rsp_id;
   logic                busy;

   int checks = 0;
   int errors = 0;

   add_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_d     (req_d),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_c[i*W +: W] = c;
      req_d[i*W +: W] = d;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      req_valid = '0;
      req_a = '0; req_b = '0; req_c = '0; req_d = '0;
      rsp_ready = 1'b1;
      rst = 1'b1;
      req_valid = 4'b1111;
      tick;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready_gated got %b want %b", req_ready, 4'b0000);
      end
      tick;
      req_valid = '0;
      rst = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
      end
      checks++;
      if (rsp_data !== 10'd0) begin
         errors++;
         $display("FAIL reset_rsp_data got %0d want 0", rsp_data);
      end
      checks++;
      if (rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_rsp_id got %0d want 0", rsp_id);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_req_ready got %b want 0000", req_ready);
      end
   endtask

   task automatic test_single;
      set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_grant got %b want 0001", req_ready);
      end
      tick;                       // T+1 (AB)
      req_valid = '0;
      #1;
      checks++;
      if (busy !== 1'b1 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL single_busy got busy=%b ready=%b want busy=1 ready=0000", busy, req_ready);
      end
      tick;                       // T+2 (CD)
      tick;                       // T+3 (SUM)
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early_valid got %b want 0", rsp_valid);
      end
      tick;                       // T+4 (DONE)
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 10'd10 || rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL single_rsp got valid=%b data=%0d id=%0d want valid=1 data=10 id=0",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick;                       // T+5 (IDLE)
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got busy=%b valid=%b want busy=0 valid=0", busy, rsp_valid);
      end
   endtask

   task automatic test_overflow;
      set_ops(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL overflow_grant got %b want 0010", req_ready);
      end
      tick;
      req_valid = '0;
      tick;
      tick;
      tick;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 10'h3FC || rsp_id !== 2'd1) begin
         errors++;
         $display("FAIL overflow_rsp got valid=%b data=%h id=%0d want valid=1 data=3fc id=1",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick;
   endtask

   task automatic test_round_robin;
      logic [3:0]   exp_grant;
      logic [W+1:0] exp_data;
      int           g;
      do_reset;
      for (int i = 0; i < NREQ; i++) begin
         set_ops(i, W'(i+1), W'(i+1), W'(i+1), W'(i+1));
      end
      req_valid = 4'b1111;
      #1;
      for (int n = 0; n < 5; n++) begin
         g         = n % 4;
         exp_grant = 4'b0001 << g;
         exp_data  = 10'((g + 1) * 4);
         checks++;
         if (req_ready !== exp_grant) begin
            errors++;
            $display("FAIL rr_grant[%0d] got %b want %b", n, req_ready, exp_grant);
         end
         tick;
         tick;
         tick;
         tick;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== IDW'(g)) begin
            errors++;
            $display("FAIL rr_rsp[%0d] got valid=%b data=%0d id=%0d want valid=1 data=%0d id=%0d",
                     n, rsp_valid, rsp_data, rsp_id, exp_data, g);
         end
         tick;
      end
      req_valid = '0;
      #1;
   endtask

   task automatic test_backpressure;
      set_ops(2, 8'd5, 8'd6, 8'd7, 8'd8);
      set_ops(3, 8'd1, 8'd1, 8'd1, 8'd1);
      req_valid = 4'b1100;
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL bp_grant got %b want 0100", req_ready);
      end
      tick;
      req_valid = 4'b1000;
      tick;
      tick;
      tick;
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 10'd26 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b data=%0d id=%0d ready=%b want valid=1 data=26 id=2 ready=0000",
                     s, rsp_valid, rsp_data, rsp_id, req_ready);
         end
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL bp_release got valid=%b ready=%b want valid=1 ready=0000", rsp_valid, req_ready);
      end
      tick;
      checks++;
      if (req_ready !== 4'b1000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_next_grant got ready=%b busy=%b want ready=1000 busy=0", req_ready, busy);
      end
      tick;
      req_valid = '0;
      tick;
      tick;
      tick;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 10'd4 || rsp_id !== 2'd3) begin
         errors++;
         $display("FAIL bp_second_rsp got valid=%b data=%0d id=%0d want valid=1 data=4 id=3",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL rmid_grant got %b want 0100", req_ready);
      end
      tick;                       // AB
      tick;                       // CD
      tick;                       // SUM
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_busy_sum got %b want 1", busy);
      end
      rst = 1'b1;
      tick;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 10'd0 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_after_rst got valid=%b busy=%b data=%0d ready=%b want valid=0 busy=0 data=0 ready=0000",
                  rsp_valid, busy, rsp_data, req_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL rmid_regrant got %b want 0100", req_ready);
      end
      tick;
      req_valid = '0;
      tick;
      tick;
      tick;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 10'd26 || rsp_id !== 2'd2) begin
         errors++;
         $display("FAIL rmid_rsp got valid=%b data=%0d id=%0d want valid=1 data=26 id=2",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick;
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL rmid_ptr got %b want 1000", req_ready);
      end
      req_valid = '0;
      #1;
   endtask

   task automatic test_skip_hole;
      logic [3:0]   exp_grant;
      logic [W+1:0] exp_data;
      int           g;
      do_reset;
      set_ops(1, 8'd1, 8'd2, 8'd3, 8'd4);
      set_ops(3, 8'd10, 8'd20, 8'd30, 8'd40);
      req_valid = 4'b1010;
      #1;
      for (int n = 0; n < 4; n++) begin
         g         = (n % 2 == 0) ? 1 : 3;
         exp_grant = 4'b0001 << g;
         exp_data  = (g == 1) ? 10'd10 : 10'd100;
         checks++;
         if (req_ready !== exp_grant) begin
            errors++;
            $display("FAIL skip_grant[%0d] got %b want %b", n, req_ready, exp_grant);
         end
         tick;
         tick;
         tick;
         tick;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== IDW'(g)) begin
            errors++;
            $display("FAIL skip_rsp[%0d] got valid=%b data=%0d id=%0d want valid=1 data=%0d id=%0d",
                     n, rsp_valid, rsp_data, rsp_id, exp_data, g);
         end
         tick;
      end
      req_valid = '0;
      #1;
   endtask

   initial begin
      test_reset;
      test_single;
      test_overflow;
      test_round_robin;
      test_backpressure;
      test_reset_mid;
      test_skip_hole;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against an unexpected hang.
   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Scheduler sharing one 2-input registered adder among NREQ requesters.
- Each request carries four unsigned operands a, b, c, d and returns the 4-way sum, computed as (a+b)+(c+d).
- Round-robin arbitration; the FSM sequences three passes through the single adder, then holds the result in a valid/ready response slot.
- Sits in front of the adder-tree datapath to replace replicated adders with one time-multiplexed unit.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- W, 8, operand width in bits.
- IDW, $clog2(NREQ), requester-ID width; minimum 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; at most one bit set.
- req_a  in  NREQ*W  packed operand a; requester i at bits [i*W +: W]. Same packing for req_b, req_c, req_d.
- req_b  in  NREQ*W  packed operand b.
- req_c  in  NREQ*W  packed operand c.
- req_d  in  NREQ*W  packed operand d.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  W+2  a+b+c+d, unsigned, never overflows.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: synchronous, active-high; clock and reset are the single clk and rst above. On rst: state=IDLE; rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0; RR pointer=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight request is dropped with no response; a pending rsp_valid is cleared.
- FSM states: IDLE -> AB -> CD -> SUM -> DONE -> IDLE.
- IDLE:
  - req_ready is combinational from req_valid: one-hot to the first valid requester searching ptr+1, ptr+2, ... modulo NREQ; 0 when no requester is valid.
  - On handshake (req_valid[g] & req_ready[g]): latch a, b, c, d and g; ptr<=g; go to AB.
- AB: adder inputs = (a, b). Registered adder output sreg <= a+b at end of cycle (W+1 bits). Go to CD.
- CD: adder inputs = (c, d); s_ab <= sreg and sreg <= c+d at the same edge. Go to SUM.
- SUM: adder inputs = (s_ab, sreg); sreg <= s_ab+sreg (W+2 bits). Go to DONE.
- DONE:
  - rsp_valid=1; rsp_data=sreg; rsp_id=latched g.
  - rsp_data and rsp_id are stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid<=0 and go to IDLE.
- Timing and throughput:
  - Latency: request accepted at cycle T, so rsp_valid is first high at T+4.
  - Max throughput is one request per 5 cycles (accept cycle plus AB, CD, SUM, DONE).
  - req_ready is 0 in every state except IDLE.
- Handshake rules:
  - A requester keeps req_valid and its operands stable until granted.
  - Deasserting req_valid before grant is legal; that requester is simply skipped.
- Fairness: a requester that keeps req_valid high is granted within NREQ grants.
- busy=1 in AB, CD, SUM and DONE.
- Arithmetic: zero-extend all operands before addition; no wrap. Worst case 4*(2^W-1) fits in W+2 bits.

Optional Feature:
- Macro ADD_SHARE_SCHED_STATS_EN. When defined, adds two output ports:
  - ops_done, 16 bits: increments on each response handshake (rsp_valid & rsp_ready), saturates at 16'hFFFF, cleared by rst.
  - stall_cycles, 16 bits: increments each cycle rsp_valid & !rsp_ready, saturates, cleared by rst.
- When not defined, these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
- Single request: rst 2 cycles; req_valid=4'b0001, a=1, b=2, c=3, d=4 with rsp_ready=1 -> req_ready=4'b0001 at T, rsp_valid at T+4 with rsp_data=10, rsp_id=0; busy low at T+5.
- Overflow bound: W=8, all operands 8'hFF -> rsp_data=10'h3FC.
- Round-robin: req_valid=4'b1111 held, operands for requester i all equal to i+1 -> grant order 0,1,2,3,0; rsp_data sequence 4,8,12,16,4; each grant 5 cycles apart.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid -> rsp_data and rsp_id stable; req_ready stays 0 throughout; next grant comes 1 cycle after the rsp_ready handshake. With ADD_SHARE_SCHED_STATS_EN, stall_cycles=6.
- Reset mid-operation: assert rst in SUM -> next cycle state=IDLE, rsp_valid=0, busy=0; with req_valid=4'b0100 still high, the first grant after reset goes to requester 2, then ptr=2.
- Skip and hole: req_valid=4'b1010 -> grants 1,3,1,3. With ADD_SHARE_SCHED_STATS_EN, ops_done=4 after four completions.
